// File: rtl/vec_pkg.sv
// Shared constants and types for the vec3 operand pair packer slice.
package vec_pkg;

  localparam int WORDS_PER_PAIR = 6;
  localparam int VEC_COMPONENTS = 3;
  localparam int VEC_DW_DEFAULT = 32;

  typedef enum logic {FILL = 1'b0, PUSH = 1'b1} pack_state_t;

  // Component k of a vector lives in element [k] (element 0 = first word popped).
  typedef logic [VEC_COMPONENTS-1:0][VEC_DW_DEFAULT-1:0] vec3_t;

endpackage

// File: rtl/fifo_array.sv
// First-word-fall-through FIFO of ARRAY_SIZE-word entries; head is a registered
// read of the storage array, re-read every cycle with a same-address write bypass.
module fifo_array #(
  parameter int DATA_WIDTH       = 32,
  parameter int ARRAY_SIZE       = 6,
  parameter int FIFO_BUFFER_SIZE = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] din,
  output logic                             full,
  input  logic                             rd_en,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] dout,
  output logic                             empty
);

  localparam int AW = (FIFO_BUFFER_SIZE > 1) ? $clog2(FIFO_BUFFER_SIZE) : 1;
  localparam int CW = $clog2(FIFO_BUFFER_SIZE + 1);
  localparam int EW = ARRAY_SIZE * DATA_WIDTH;

  logic [EW-1:0] mem [FIFO_BUFFER_SIZE];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] head_q;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(FIFO_BUFFER_SIZE));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign dout  = head_q;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Head tracks the entry at the next read pointer; bypass covers a write landing there.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= din;
    end
    head_q <= (push && (wr_ptr_q == rd_ptr_d)) ? din : mem[rd_ptr_d];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vec_pair_packer_core.sv
// Pair assembly FSM: pops six words into slots, then writes them as one entry.
// pair_count exists only when VEC_PAIR_PACK_STATS_EN is defined.
module vec_pair_packer_core
  import vec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                din,
  input  logic                                 in_empty,
  output logic                                 in_rd_en,
  input  logic                                 flush,
  input  logic                                 out_full,
  output logic                                 wr_en,
  output logic [WORDS_PER_PAIR*DATA_WIDTH-1:0] wr_data
`ifdef VEC_PAIR_PACK_STATS_EN
  ,
  output logic [31:0]                          pair_count
`endif
);

  pack_state_t state_q, state_d;
  logic [2:0]  idx_q, idx_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    in_rd_en = 1'b0;
    wr_en    = 1'b0;
    if (flush) begin
      state_d = FILL;
      idx_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (!in_empty) begin
            in_rd_en = 1'b1;
            if (idx_q == 3'(WORDS_PER_PAIR - 1)) begin
              idx_d   = '0;
              state_d = PUSH;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        PUSH: begin
          if (!out_full) begin
            wr_en   = 1'b1;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
    // The upstream pop is combinational, so it must be masked during async reset.
    if (reset) begin
      in_rd_en = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  for (genvar gi = 0; gi < WORDS_PER_PAIR; gi++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        slot_q <= '0;
      end else if (in_rd_en && (idx_q == 3'(gi))) begin
        slot_q <= din;
      end
    end

    assign wr_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q;
  end

`ifdef VEC_PAIR_PACK_STATS_EN
  logic [31:0] pair_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_count_q <= '0;
    end else if (wr_en) begin
      pair_count_q <= pair_count_q + 32'd1;
    end
  end

  assign pair_count = pair_count_q;
`endif

endmodule

// File: rtl/vec_pair_packer.sv
// Packs a scalar word stream into x/y vec3 operand pairs behind an output FIFO.
// Optional pair counter port enabled by defining VEC_PAIR_PACK_STATS_EN.
module vec_pair_packer
  import vec_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int FIFO_BUFFER_SIZE = 1024
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [DATA_WIDTH-1:0]                    din,
  input  logic                                     in_empty,
  output logic                                     in_rd_en,
  input  logic                                     flush,
  output logic [VEC_COMPONENTS-1:0][DATA_WIDTH-1:0] x,
  output logic [VEC_COMPONENTS-1:0][DATA_WIDTH-1:0] y,
  output logic                                     out_empty,
  input  logic                                     out_rd_en
`ifdef VEC_PAIR_PACK_STATS_EN
  ,
  output logic [31:0]                              pair_count
`endif
);

  localparam int VW = VEC_COMPONENTS * DATA_WIDTH;

  logic                                 wr_en;
  logic                                 out_full;
  logic [WORDS_PER_PAIR*DATA_WIDTH-1:0] wr_data;
  logic [WORDS_PER_PAIR*DATA_WIDTH-1:0] head;

  vec_pair_packer_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .flush      (flush),
    .out_full   (out_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data)
`ifdef VEC_PAIR_PACK_STATS_EN
    ,
    .pair_count (pair_count)
`endif
  );

  fifo_array #(
    .DATA_WIDTH       (DATA_WIDTH),
    .ARRAY_SIZE       (WORDS_PER_PAIR),
    .FIFO_BUFFER_SIZE (FIFO_BUFFER_SIZE)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (wr_en),
    .din   (wr_data),
    .full  (out_full),
    .rd_en (out_rd_en),
    .dout  (head),
    .empty (out_empty)
  );

  // Entry words 0-2 are x[0..2], words 3-5 are y[0..2].
  assign x = head[VW-1:0];
  assign y = head[2*VW-1:VW];

endmodule
